// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell shared over WIDTH clocks, LSB first.
// Optional subtract path enabled by defining SERIAL_ADD_SUB_EN (adds the 'sub' port).

module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic c
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] msb_in;
  logic [WIDTH-1:0] b_load;
  logic             carry;
  logic             carry_load;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (carry)
  );

  assign accept   = in_valid & in_ready;
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign sum      = result;
  assign cout     = carry;

  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
  always_comb begin
    b_load     = b;
    carry_load = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load     = ~b;
      carry_load = 1'b1;
    end
`endif
  end

  always_comb begin
    msb_in            = '0;
    msb_in[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The result register fills from the top so the LSB lands in bit 0 after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      result <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      result <= (result >> 1) | msb_in;
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy, cin, cout;
  logic [7:0] a, b, sum;
  logic       in_valid_w1, in_ready_w1, out_valid_w1, out_ready_w1, busy_w1, cin_w1, cout_w1;
  logic [0:0] a_w1, b_w1, sum_w1;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub, sub_w1;
`endif

  int checks;
  int passed;

  serial_adder_ctrl #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_w1),
    .in_ready  (in_ready_w1),
    .a         (a_w1),
    .b         (b_w1),
    .cin       (cin_w1),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub_w1),
`endif
    .out_valid (out_valid_w1),
    .out_ready (out_ready_w1),
    .sum       (sum_w1),
    .cout      (cout_w1),
    .busy      (busy_w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
`ifdef SERIAL_ADD_SUB_EN
    sub      = sv;
`else
    if (sv) $display("[TB] note: subtract requested in add-only build");
`endif
    step();
    in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until out_valid, bounded so a stuck DUT still terminates.
  task automatic wait8(output int cyc, output int busy_cyc);
    cyc      = 0;
    busy_cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) busy_cyc++;
      step();
      cyc++;
    end
  endtask

  task automatic release8();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else passed++;
    checks++; if (sum !== 8'h00) $display("[TB] FAIL rst_sum: got %h expected 00", sum); else passed++;
    checks++; if (cout !== 1'b0) $display("[TB] FAIL rst_cout: got %b expected 0", cout); else passed++;
    checks++; if (in_ready_w1 !== 1'b1) $display("[TB] FAIL rst_w1_in_ready: got %b expected 1", in_ready_w1); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_add();
    int cyc, bcyc;
    start8(8'h35, 8'h1A, 1'b0, 1'b0);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL t1_busy_after_accept: got %b expected 1", busy); else passed++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL t1_in_ready_run: got %b expected 0", in_ready); else passed++;
    wait8(cyc, bcyc);
    checks++; if (cyc !== 8) $display("[TB] FAIL t1_latency: got %0d expected 8", cyc); else passed++;
    checks++; if (bcyc !== 8) $display("[TB] FAIL t1_busy_cycles: got %0d expected 8", bcyc); else passed++;
    checks++; if (sum !== 8'h4F) $display("[TB] FAIL t1_sum: got %h expected 4f", sum); else passed++;
    checks++; if (cout !== 1'b0) $display("[TB] FAIL t1_cout: got %b expected 0", cout); else passed++;
    release8();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL t1_out_valid_drop: got %b expected 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL t1_in_ready_back: got %b expected 1", in_ready); else passed++;
    checks++; if (sum !== 8'h4F) $display("[TB] FAIL t1_sum_held_idle: got %h expected 4f", sum); else passed++;
  endtask

  task automatic test_carry();
    int cyc, bcyc;
    start8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait8(cyc, bcyc);
    checks++; if (sum !== 8'h00) $display("[TB] FAIL t2a_sum: got %h expected 00", sum); else passed++;
    checks++; if (cout !== 1'b1) $display("[TB] FAIL t2a_cout: got %b expected 1", cout); else passed++;
    release8();
    start8(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait8(cyc, bcyc);
    checks++; if (sum !== 8'hFF) $display("[TB] FAIL t2b_sum: got %h expected ff", sum); else passed++;
    checks++; if (cout !== 1'b1) $display("[TB] FAIL t2b_cout: got %b expected 1", cout); else passed++;
    checks++; if (cyc !== 8) $display("[TB] FAIL t2b_latency: got %0d expected 8", cyc); else passed++;
    release8();
  endtask

  task automatic test_stall();
    int cyc, bcyc;
    start8(8'h12, 8'h34, 1'b0, 1'b0);
    wait8(cyc, bcyc);
    in_valid  = 1'b1;
    a         = 8'hAA;
    b         = 8'h55;
    cin       = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL t3_out_valid_hold: got %b expected 1", out_valid); else passed++;
      checks++; if (sum !== 8'h46) $display("[TB] FAIL t3_sum_hold: got %h expected 46", sum); else passed++;
      checks++; if (cout !== 1'b0) $display("[TB] FAIL t3_cout_hold: got %b expected 0", cout); else passed++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL t3_in_ready_hold: got %b expected 0", in_ready); else passed++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL t3_handshake_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL t3_handshake_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL t3_no_early_accept: got %b expected 0", busy); else passed++;
    step();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL t3_late_accept: got %b expected 1", busy); else passed++;
    wait8(cyc, bcyc);
    checks++; if (cyc !== 8) $display("[TB] FAIL t3_latency: got %0d expected 8", cyc); else passed++;
    checks++; if ({cout, sum} !== 9'h100) $display("[TB] FAIL t3_result: got %h expected 100", {cout, sum}); else passed++;
    release8();
  endtask

  task automatic test_abort();
    int cyc, bcyc;
    start8(8'h5A, 8'h3C, 1'b1, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL t4_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL t4_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (sum !== 8'h00) $display("[TB] FAIL t4_sum: got %h expected 00", sum); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL t4_busy: got %b expected 0", busy); else passed++;
    rst_n = 1'b1;
    start8(8'h01, 8'h01, 1'b0, 1'b0);
    wait8(cyc, bcyc);
    checks++; if (sum !== 8'h02) $display("[TB] FAIL t4_sum_after: got %h expected 02", sum); else passed++;
    checks++; if (cout !== 1'b0) $display("[TB] FAIL t4_cout_after: got %b expected 0", cout); else passed++;
    release8();
  endtask

  task automatic test_back_to_back();
    int n;
    logic prev;
    a         = 8'h01;
    b         = 8'h02;
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    prev = busy;
    n    = 0;
    while (n < 30) begin
      step();
      n++;
      if (busy && !prev) break;
      prev = busy;
    end
    checks++; if (n !== 10) $display("[TB] FAIL b2b_period: got %0d expected 10", n); else passed++;
    in_valid = 1'b0;
    repeat (12) step();
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_drained: got %b expected 1", in_ready); else passed++;
    checks++; if ({cout, sum} !== 9'h003) $display("[TB] FAIL b2b_result: got %h expected 003", {cout, sum}); else passed++;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_subtract();
    int cyc, bcyc;
    start8(8'h10, 8'h01, 1'b0, 1'b1);
    wait8(cyc, bcyc);
    checks++; if (sum !== 8'h0F) $display("[TB] FAIL t5a_sum: got %h expected 0f", sum); else passed++;
    checks++; if (cout !== 1'b1) $display("[TB] FAIL t5a_cout: got %b expected 1", cout); else passed++;
    release8();
    start8(8'h01, 8'h02, 1'b1, 1'b1);
    wait8(cyc, bcyc);
    checks++; if (sum !== 8'hFF) $display("[TB] FAIL t5b_sum: got %h expected ff", sum); else passed++;
    checks++; if (cout !== 1'b0) $display("[TB] FAIL t5b_cout: got %b expected 0", cout); else passed++;
    release8();
    sub = 1'b0;
  endtask
`endif

  task automatic test_width1();
    int cyc;
    logic [1:0] expv;
    for (int i = 0; i < 8; i++) begin
      a_w1        = 1'(i >> 2);
      b_w1        = 1'(i >> 1);
      cin_w1      = 1'(i);
      expv        = 2'(a_w1) + 2'(b_w1) + 2'(cin_w1);
      in_valid_w1 = 1'b1;
      step();
      in_valid_w1 = 1'b0;
      cyc = 0;
      while (!out_valid_w1 && cyc < 20) begin
        step();
        cyc++;
      end
      checks++; if (cyc !== 1) $display("[TB] FAIL w1_latency: got %0d expected 1", cyc); else passed++;
      checks++; if ({cout_w1, sum_w1} !== expv) $display("[TB] FAIL w1_result: got %b expected %b", {cout_w1, sum_w1}, expv); else passed++;
      out_ready_w1 = 1'b1;
      step();
      out_ready_w1 = 1'b0;
    end
  endtask

  task automatic test_random();
    int cyc, bcyc;
    logic [7:0] av, bv;
    logic       cv, sv;
    logic [8:0] expv;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      cv = 1'($urandom);
      sv = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sv = 1'($urandom);
`endif
      expv = sv ? ({1'b0, av} + {1'b0, ~bv} + 9'd1) : ({1'b0, av} + {1'b0, bv} + {8'd0, cv});
      start8(av, bv, cv, sv);
      wait8(cyc, bcyc);
      checks++; if (cyc !== 8) $display("[TB] FAIL rnd_latency: got %0d expected 8", cyc); else passed++;
      checks++; if ({cout, sum} !== expv) $display("[TB] FAIL rnd_result: got %h expected %h (a=%h b=%h cin=%b)", {cout, sum}, expv, av, bv, cv); else passed++;
      repeat ($urandom_range(0, 3)) step();
      release8();
    end
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    a            = '0;
    b            = '0;
    cin          = 1'b0;
    in_valid_w1  = 1'b0;
    out_ready_w1 = 1'b0;
    a_w1         = '0;
    b_w1         = '0;
    cin_w1       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub          = 1'b0;
    sub_w1       = 1'b0;
`endif
    $display("[TB] starting serial_adder_ctrl bench");
    test_reset();
    test_basic_add();
    test_carry();
    test_stall();
    test_abort();
    test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
    test_subtract();
`endif
    test_width1();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
